// File: rtl/vga_pattern_engine.sv
// rtl/vga_pattern_engine.sv - VGA raster timing generator with selectable test patterns
module vga_pattern_engine #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int COLOR_W   = 4,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CHK_SHIFT = 5,
  parameter int RADIUS    = 200,
  parameter int BOX_SIZE  = 32
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         mode,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int BX_MAX   = H_DISPLAY - BOX_SIZE;
  localparam int BY_MAX   = V_DISPLAY - BOX_SIZE;
  localparam int BAR_W    = H_DISPLAY / 8;

  // Circle arithmetic width: enough for the squared distance of any raster
  // position and for RADIUS squared, plus a sign bit.
  localparam int RW  = $clog2(RADIUS + 1);
  localparam int MW0 = (HW > VW) ? HW : VW;
  localparam int MW  = (MW0 > RW) ? MW0 : RW;
  localparam int SW  = 2 * MW + 3;
  localparam logic signed [SW-1:0] R2 = SW'(RADIUS * RADIUS);

  localparam logic [COLOR_W-1:0] C_FULL = '1;
  localparam logic [COLOR_W-1:0] C_ZERO = '0;
  localparam logic [COLOR_W-1:0] C_HALF = COLOR_W'(1) << (COLOR_W - 1);
  localparam logic HS_ACT = (HSYNC_POL != 0);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  // Raster position and per-frame state
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_wrap;
  logic          v_last;
  logic          frame_wrap;
  logic [2:0]    active_mode;
  logic [HW-1:0] bx;
  logic [VW-1:0] by;
  logic          dir_x;
  logic          dir_y;
  logic [HW-1:0] scroll_off;

  // Pixel generation (stage 0, combinational)
  logic               in_active;
  logic               hs_on;
  logic               vs_on;
  logic               chk_on;
  logic               in_box;
  logic               in_circle;
  logic signed [SW-1:0] dx;
  logic signed [SW-1:0] dy;
  logic signed [SW-1:0] dist2;
  int                 xs;
  int                 grad_r;
  int                 grad_g;
  logic [COLOR_W-1:0] pr;
  logic [COLOR_W-1:0] pg;
  logic [COLOR_W-1:0] pb;

  // First pipeline stage
  logic               s1_de;
  logic               s1_hs;
  logic               s1_vs;
  logic               s1_fs;
  logic [COLOR_W-1:0] s1_r;
  logic [COLOR_W-1:0] s1_g;
  logic [COLOR_W-1:0] s1_b;

  assign h_wrap     = (h == HW'(H_TOTAL - 1));
  assign v_last     = (v == VW'(V_TOTAL - 1));
  assign frame_wrap = en && h_wrap && v_last;

  // Eight-bar palette: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [3*COLOR_W-1:0] bar_rgb(input int xx);
    int         idx;
    logic [2:0] i3;
    idx = xx / BAR_W;
    if (idx > 7) idx = 7;
    i3 = 3'(idx);
    bar_rgb = {i3[1] ? C_ZERO : C_FULL,
               i3[2] ? C_ZERO : C_FULL,
               i3[0] ? C_ZERO : C_FULL};
  endfunction

  // Raster counters: held at the origin while disabled so a restart begins at (0,0)
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (!en) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= v_last ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Pattern select only changes between frames (or while idle) to avoid tearing
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      active_mode <= '0;
    end else if (!en || frame_wrap) begin
      active_mode <= mode;
    end
  end

  // Once-per-frame state: frame counter, scroll offset and bouncing box
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      frame_cnt  <= '0;
      scroll_off <= '0;
      bx         <= '0;
      by         <= '0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
    end else if (frame_wrap) begin
      frame_cnt  <= frame_cnt + 16'd1;
      scroll_off <= (scroll_off == HW'(H_DISPLAY - 1)) ? '0 : scroll_off + HW'(1);
      if (dir_x) begin
        if (bx == HW'(BX_MAX)) begin
          bx    <= bx - HW'(1);
          dir_x <= 1'b0;
        end else begin
          bx <= bx + HW'(1);
        end
      end else begin
        if (bx == '0) begin
          bx    <= HW'(1);
          dir_x <= 1'b1;
        end else begin
          bx <= bx - HW'(1);
        end
      end
      if (dir_y) begin
        if (by == VW'(BY_MAX)) begin
          by    <= by - VW'(1);
          dir_y <= 1'b0;
        end else begin
          by <= by + VW'(1);
        end
      end else begin
        if (by == '0) begin
          by    <= VW'(1);
          dir_y <= 1'b1;
        end else begin
          by <= by - VW'(1);
        end
      end
    end
  end

  // Geometry terms shared by the patterns
  assign in_active = (int'(h) < H_DISPLAY) && (int'(v) < V_DISPLAY);
  assign hs_on     = (int'(h) >= HS_START) && (int'(h) < HS_END);
  assign vs_on     = (int'(v) >= VS_START) && (int'(v) < VS_END);
  assign chk_on    = (((int'(h) ^ int'(v)) >> CHK_SHIFT) & 1) != 0;
  assign in_box    = (int'(h) >= int'(bx)) && (int'(h) < int'(bx) + BOX_SIZE) &&
                     (int'(v) >= int'(by)) && (int'(v) < int'(by) + BOX_SIZE);
  assign dx        = SW'(int'(h) - H_DISPLAY / 2);
  assign dy        = SW'(int'(v) - V_DISPLAY / 2);
  assign dist2     = dx * dx + dy * dy;
  assign in_circle = (dist2 <= R2);

  // Pattern colour for the current raster position; blanking forces black
  always_comb begin
    pr     = C_ZERO;
    pg     = C_ZERO;
    pb     = C_ZERO;
    xs     = int'(h) + int'(scroll_off);
    grad_r = (int'(h) << COLOR_W) / H_DISPLAY;
    grad_g = (int'(v) << COLOR_W) / V_DISPLAY;
    if (xs >= H_DISPLAY) xs = xs - H_DISPLAY;
    case (active_mode)
      3'd0: {pr, pg, pb} = bar_rgb(int'(h));
      3'd1: if (chk_on) {pr, pg, pb} = {C_FULL, C_FULL, C_FULL};
      3'd2: begin
        pr = COLOR_W'(grad_r);
        pg = COLOR_W'(grad_g);
        pb = C_HALF;
      end
      3'd3: if (in_circle) {pr, pg, pb} = {C_FULL, C_FULL, C_FULL};
      3'd4: begin
        if (in_box) {pr, pg, pb} = {C_FULL, C_FULL, C_FULL};
        else        pb = C_HALF;
      end
      3'd5: {pr, pg, pb} = bar_rgb(xs);
      default: ;
    endcase
    if (!in_active) begin
      pr = C_ZERO;
      pg = C_ZERO;
      pb = C_ZERO;
    end
  end

  // Stage 1: capture timing flags and colour; everything is qualified by en
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      s1_de <= 1'b0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_fs <= 1'b0;
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
    end else begin
      s1_de <= en && in_active;
      s1_hs <= en && hs_on;
      s1_vs <= en && vs_on;
      s1_fs <= en && (h == '0) && (v == '0);
      s1_r  <= (en && in_active) ? pr : C_ZERO;
      s1_g  <= (en && in_active) ? pg : C_ZERO;
      s1_b  <= (en && in_active) ? pb : C_ZERO;
    end
  end

  // Stage 2: output registers, sync polarity applied here
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      de          <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      hsync       <= s1_hs ? HS_ACT : ~HS_ACT;
      vsync       <= s1_vs ? VS_ACT : ~VS_ACT;
      de          <= s1_de;
      frame_start <= s1_fs;
      r           <= s1_r;
      g           <= s1_g;
      b           <= s1_b;
    end
  end

endmodule

// File: tb/tb_vga_pattern_engine.sv
// tb/tb_vga_pattern_engine.sv - directed self-checking bench for vga_pattern_engine
module tb_vga_pattern_engine;

  // Reduced raster: 40 x 30 total, 32 x 24 active, 1200 cycles per frame
  localparam int HD = 32, HF = 2, HS = 4, HB = 2;
  localparam int VD = 24, VF = 2, VS = 2, VB = 2;
  localparam int CW = 4;
  localparam int FR = 1200;

  logic          clk_pix = 1'b0;
  logic          rst     = 1'b0;
  logic          en      = 1'b0;
  logic [2:0]    mode    = 3'd0;
  logic          hsync, vsync, de, frame_start;
  logic [CW-1:0] r, g, b;
  logic [15:0]   frame_cnt;

  int errors = 0;
  int checks = 0;
  int ed     = 0;
  int hs_lo, vs_lo, de_hi, fs_hi, bad_blank;
  logic [3*CW-1:0] rgb_mem [FR];

  always #5 clk_pix = ~clk_pix;

  vga_pattern_engine #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLOR_W(CW), .HSYNC_POL(0), .VSYNC_POL(0),
    .CHK_SHIFT(2), .RADIUS(10), .BOX_SIZE(8)
  ) dut (
    .clk_pix(clk_pix), .rst(rst), .en(en), .mode(mode),
    .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until the outputs show pixel index n (counted from the en rising edge)
  task automatic adv_to(input int n);
    if (ed > n + 2) begin
      checks++;
      errors++;
      $display("FAIL adv_to target=%0d already passed at edge=%0d", n, ed);
    end
    while (ed < n + 2) begin
      @(posedge clk_pix);
      ed++;
    end
    #1;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk_pix);
    #1;
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'h000);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk_pix);
    #1;
    chk("idle_de", 32'(de), 32'd0);
    en = 1'b1;
    ed = 0;

    // Frame 0: colour bars, sync placement
    adv_to(0);
    chk("f0_fs", 32'(frame_start), 32'd1);
    chk("f0_px0", 32'({r, g, b}), 32'hFFF);
    adv_to(1);
    chk("f0_fs_pulse", 32'(frame_start), 32'd0);
    adv_to(3);
    chk("bar_px3_white", 32'({r, g, b}), 32'hFFF);
    adv_to(4);
    chk("bar_px4_yellow", 32'({r, g, b}), 32'hFF0);
    adv_to(20);
    chk("bar_px20_red", 32'({r, g, b}), 32'hF00);
    adv_to(31);
    chk("bar_px31_black", 32'({r, g, b}), 32'h000);
    chk("bar_px31_de", 32'(de), 32'd1);
    mode = 3'd3;
    adv_to(32);
    chk("px32_de", 32'(de), 32'd0);
    chk("px32_still_bars_blank", 32'({r, g, b}), 32'h000);
    adv_to(33);
    chk("px33_hsync", 32'(hsync), 32'd1);
    adv_to(34);
    chk("px34_hsync", 32'(hsync), 32'd0);
    adv_to(37);
    chk("px37_hsync", 32'(hsync), 32'd0);
    adv_to(38);
    chk("px38_hsync", 32'(hsync), 32'd1);
    adv_to(40 + 4);
    chk("line1_bars_mid_frame", 32'({r, g, b}), 32'hFF0);

    // Frame 1: circle centred at (16,12), radius 10
    adv_to(FR + 1 * 40 + 16);
    chk("circ_16_1_out", 32'({r, g, b}), 32'h000);
    adv_to(FR + 2 * 40 + 16);
    chk("circ_16_2_edge", 32'({r, g, b}), 32'hFFF);
    adv_to(FR + 12 * 40 + 26);
    chk("circ_26_12_edge", 32'({r, g, b}), 32'hFFF);
    adv_to(FR + 12 * 40 + 27);
    chk("circ_27_12_out", 32'({r, g, b}), 32'h000);
    mode = 3'd1;

    // Frame 2: checker, with full-frame timing counts
    hs_lo = 0; vs_lo = 0; de_hi = 0; fs_hi = 0; bad_blank = 0;
    for (int i = 0; i < FR; i++) begin
      adv_to(2 * FR + i);
      if (!hsync) hs_lo++;
      if (!vsync) vs_lo++;
      if (de) de_hi++;
      if (frame_start) fs_hi++;
      if (!de && ({r, g, b} != '0)) bad_blank++;
      rgb_mem[i] = {r, g, b};
    end
    chk("frame_hsync_low", 32'(hs_lo), 32'd120);
    chk("frame_vsync_low", 32'(vs_lo), 32'd80);
    chk("frame_de_high", 32'(de_hi), 32'd768);
    chk("frame_fs_count", 32'(fs_hi), 32'd1);
    chk("blank_rgb_zero", 32'(bad_blank), 32'd0);
    chk("fcnt_after_f2", 32'(frame_cnt), 32'd3);
    chk("chk_0_0", 32'(rgb_mem[0]), 32'h000);
    chk("chk_4_0", 32'(rgb_mem[4]), 32'hFFF);
    chk("chk_4_4", 32'(rgb_mem[4 * 40 + 4]), 32'h000);
    chk("chk_0_4", 32'(rgb_mem[4 * 40]), 32'hFFF);

    // Frame 3: mode changed to gradient mid-frame; checker persists
    mode = 3'd2;
    adv_to(3 * FR + 4);
    chk("f3_chk_4_0", 32'({r, g, b}), 32'hFFF);
    adv_to(3 * FR + 20 * 40);
    chk("f3_chk_0_20", 32'({r, g, b}), 32'hFFF);
    adv_to(3 * FR + 20 * 40 + 4);
    chk("f3_chk_4_20", 32'({r, g, b}), 32'h000);

    // Frame 4: gradient
    adv_to(4 * FR);
    chk("f4_fs", 32'(frame_start), 32'd1);
    chk("grad_0_0", 32'({r, g, b}), 32'h008);
    adv_to(4 * FR + 3 * 40 + 5);
    chk("grad_5_3", 32'({r, g, b}), 32'h228);
    adv_to(4 * FR + 5 * 40 + 35);
    chk("grad_blank", 32'({r, g, b}), 32'h000);
    adv_to(4 * FR + 12 * 40 + 16);
    chk("grad_16_12", 32'({r, g, b}), 32'h888);
    adv_to(4 * FR + 23 * 40 + 31);
    chk("grad_31_23", 32'({r, g, b}), 32'hFF8);
    mode = 3'd5;

    // Frame 5: scrolling bars, offset 5
    adv_to(5 * FR);
    chk("scroll_fcnt", 32'(frame_cnt), 32'd5);
    chk("scroll_x0_yellow", 32'({r, g, b}), 32'hFF0);
    adv_to(5 * FR + 3);
    chk("scroll_x3_cyan", 32'({r, g, b}), 32'h0FF);
    adv_to(5 * FR + 26);
    chk("scroll_x26_black", 32'({r, g, b}), 32'h000);
    adv_to(5 * FR + 27);
    chk("scroll_x27_white", 32'({r, g, b}), 32'hFFF);
    mode = 3'd4;

    // Frames 6..25: bouncing box (bx max 24, by max 16)
    adv_to(6 * FR + 6 * 40 + 5);
    chk("box6_5_6_bg", 32'({r, g, b}), 32'h008);
    adv_to(6 * FR + 6 * 40 + 6);
    chk("box6_6_6_in", 32'({r, g, b}), 32'hFFF);
    adv_to(6 * FR + 13 * 40 + 13);
    chk("box6_13_13_in", 32'({r, g, b}), 32'hFFF);
    adv_to(6 * FR + 13 * 40 + 14);
    chk("box6_14_13_bg", 32'({r, g, b}), 32'h008);
    adv_to(6 * FR + 14 * 40 + 13);
    chk("box6_13_14_bg", 32'({r, g, b}), 32'h008);
    adv_to(16 * FR + 15 * 40 + 16);
    chk("box16_16_15_bg", 32'({r, g, b}), 32'h008);
    adv_to(16 * FR + 23 * 40 + 16);
    chk("box16_16_23_in", 32'({r, g, b}), 32'hFFF);
    adv_to(17 * FR + 15 * 40 + 17);
    chk("box17_17_15_in", 32'({r, g, b}), 32'hFFF);
    adv_to(17 * FR + 23 * 40 + 17);
    chk("box17_17_23_bg", 32'({r, g, b}), 32'h008);
    adv_to(24 * FR + 8 * 40 + 23);
    chk("box24_23_8_bg", 32'({r, g, b}), 32'h008);
    adv_to(24 * FR + 8 * 40 + 31);
    chk("box24_31_8_in", 32'({r, g, b}), 32'hFFF);
    adv_to(25 * FR + 7 * 40 + 30);
    chk("box25_30_7_in", 32'({r, g, b}), 32'hFFF);
    adv_to(25 * FR + 7 * 40 + 31);
    chk("box25_31_7_bg", 32'({r, g, b}), 32'h008);

    // en falls mid-frame: outputs drain, state holds
    en = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    chk("dis_de", 32'(de), 32'd0);
    chk("dis_hsync", 32'(hsync), 32'd1);
    chk("dis_vsync", 32'(vsync), 32'd1);
    chk("dis_fs", 32'(frame_start), 32'd0);
    chk("dis_rgb", 32'({r, g, b}), 32'h000);
    chk("dis_fcnt", 32'(frame_cnt), 32'd25);

    // en rises: restart at (0,0) with held box position (23,7)
    en = 1'b1;
    ed = 0;
    adv_to(0);
    chk("re_fs", 32'(frame_start), 32'd1);
    chk("re_px0_bg", 32'({r, g, b}), 32'h008);
    adv_to(1);
    chk("re_fs_pulse", 32'(frame_start), 32'd0);
    adv_to(10);
    chk("pre_rst_de", 32'(de), 32'd1);

    // Asynchronous reset mid-line
    #2 rst = 1'b1;
    #1;
    chk("arst_de", 32'(de), 32'd0);
    chk("arst_hsync", 32'(hsync), 32'd1);
    chk("arst_rgb", 32'({r, g, b}), 32'h000);
    chk("arst_fcnt", 32'(frame_cnt), 32'd0);
    mode = 3'd0;
    @(posedge clk_pix);
    #1;
    rst = 1'b0;
    ed = 0;
    adv_to(0);
    chk("post_rst_fs", 32'(frame_start), 32'd1);
    chk("post_rst_px0", 32'({r, g, b}), 32'hFFF);
    adv_to(4);
    chk("post_rst_px4", 32'({r, g, b}), 32'hFF0);
    chk("post_rst_fcnt", 32'(frame_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_engine.md
VGA_PATTERN_ENGINE -- requirements
Module: vga_pattern_engine

Interface
REQ-001 SHALL have parameter H_DISPLAY, 640: active pixels per line.
REQ-002 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal porch and sync widths in pixels; H_TOTAL = sum of the four.
REQ-003 SHALL have parameters V_DISPLAY 480, V_FRONT 10, V_SYNC 2, V_BACK 33: vertical widths in lines; V_TOTAL = sum of the four.
REQ-004 SHALL have parameter COLOR_W, 4: bits per colour channel (range 1..8).
REQ-005 SHALL have parameters HSYNC_POL 0 and VSYNC_POL 0: sync active level (0 = active-low).
REQ-006 SHALL have parameter CHK_SHIFT, 5: the checker square edge is 2^CHK_SHIFT pixels.
REQ-007 SHALL have parameter RADIUS, 200: circle radius in pixels.
REQ-008 SHALL have parameter BOX_SIZE, 32: bouncing-box edge in pixels.
REQ-009 SHALL have port clk_pix, input, 1: pixel clock.
REQ-010 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-011 SHALL have port en, input, 1: run enable (e.g. PLL locked).
REQ-012 SHALL have port mode, input, 3: pattern select.
REQ-013 SHALL have ports hsync and vsync, output, 1 each: sync outputs at the polarity set by the parameters.
REQ-014 SHALL have port de, output, 1: data enable, high for active pixels.
REQ-015 SHALL have ports r, g and b, output, COLOR_W each: pixel colour.
REQ-016 SHALL have port frame_start, output, 1: one-cycle pulse aligned with pixel (0,0).
REQ-017 SHALL have port frame_cnt, output, 16: completed-frame count.

Function
REQ-018 SHALL keep internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), each $clog2 of its total in width; h increments every cycle; v increments when h wraps; both wrap to 0.
REQ-019 SHALL assert sync for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC) and for v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC).
REQ-020 SHALL register every output with a fixed latency of 2 clk_pix cycles from counter value (h,v) to hsync/vsync/de/r/g/b/frame_start for that pixel; all outputs SHALL be mutually aligned.
REQ-021 SHALL drive r=g=b=0 whenever de=0.
REQ-022 SHALL latch mode into an active_mode register only on the frame-wrap cycle (h=H_TOTAL-1, v=V_TOTAL-1) or while en=0; mid-frame mode changes have no effect until the next frame.
REQ-023 SHALL implement mode 0, colour bars: eight bars each H_DISPLAY/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black; full scale = all ones.
REQ-024 SHALL implement mode 1, checker: white when x[CHK_SHIFT]^y[CHK_SHIFT]=1, else black.
REQ-025 SHALL implement mode 2, gradient: r=floor(x*2^COLOR_W/H_DISPLAY), g=floor(y*2^COLOR_W/V_DISPLAY), b=2^(COLOR_W-1).
REQ-026 SHALL implement mode 3, circle: white when dx²+dy² <= RADIUS², where dx=x-H_DISPLAY/2 and dy=y-V_DISPLAY/2, using signed arithmetic wide enough that nothing overflows; boundary inclusive; black otherwise.
REQ-027 SHALL implement mode 4, bouncing box: white when bx<=x<bx+BOX_SIZE and by<=y<by+BOX_SIZE, else dark blue (b = 2^(COLOR_W-1), r=g=0).
REQ-028 SHALL implement mode 5, scrolling bars: the mode 0 bars with bar index taken from (x+frame_cnt) mod H_DISPLAY.
REQ-029 SHALL output black in modes 6 and 7.
REQ-030 SHALL update box position once per frame on the frame-wrap cycle: ±1 pixel per axis; when moving + and already at the maximum (H_DISPLAY-BOX_SIZE or V_DISPLAY-BOX_SIZE), or moving - and already at 0, SHALL reverse direction and step 1 the other way that same update.
REQ-031 SHALL increment frame_cnt on each frame-wrap cycle, wrapping 0xFFFF->0; box and frame_cnt SHALL update in all modes.
REQ-032 SHALL, while en=0, hold h=v=0, hold box position and frame_cnt, and drive syncs inactive, de=0, rgb=0, frame_start=0 after the pipeline drains.
REQ-033 SHALL, on en falling mid-frame, clear the counters on the next edge; on en rising, start at (0,0) and pulse frame_start 2 cycles later.

Reset
REQ-034 SHALL, on rst, asynchronously clear h, v, pipeline, frame_cnt, bx, by and active_mode to 0, set box direction to +x,+y, drive hsync/vsync inactive and de/rgb/frame_start to 0; after release, counting SHALL begin on the first edge with en=1.

Verification
REQ-035 SHALL cover: default parameters, en=1 for 2 frames -> hsync low for exactly 96 cycles per 800-cycle line, vsync low for exactly 2 lines per 525-line frame, de high 640x480 per frame, frame_start period 420000 cycles.
REQ-036 SHALL cover: mode 0 -> pixel 79 white, pixel 80 yellow (F,F,0), pixel 639 black, all appearing 2 cycles after the counter value.
REQ-037 SHALL cover: mode 3 -> pixel (520,240) white (dx=200), pixel (521,240) black.
REQ-038 SHALL cover: mode 4 over 700 frames -> bx reaches 608 at frame 608 then 607; by reaches 448 then decreases; box never leaves the active area.
REQ-039 SHALL cover: mode switched 1->2 mid-frame -> output stays checker until the next frame_start, then shows gradient.
REQ-040 SHALL cover: rst asserted mid-line -> outputs go to reset values immediately (asynchronously); frame_cnt=0; restart resumes at (0,0).
